// File: rtl/d_store_split_pkg.sv
// Shared data-cache store definitions: opcodes, size encodings, FSM states and
// line-geometry helpers used by the store split path.
package d_store_split_pkg;

  typedef enum logic [2:0] {
    OP_NOOP  = 3'd0,
    OP_LD    = 3'd1,
    OP_ST    = 3'd2,
    OP_RD    = 3'd3,
    OP_WR    = 3'd4,
    OP_INV   = 3'd5,
    OP_UPD   = 3'd6,
    OP_WR_LD = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    SZ_BYTE    = 2'd0,
    SZ_HALF    = 2'd1,
    SZ_ILLEGAL = 2'd2,
    SZ_WORD    = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_e;

  // Offset field width; the bank select bit sits directly above it.
  function automatic int unsigned off_bits(input int unsigned cl_size);
    return $clog2(cl_size / 8);
  endfunction

  function automatic logic [3:0] size_mask(input logic [1:0] size);
    case (size)
      SZ_BYTE: return 4'b0001;
      SZ_HALF: return 4'b0011;
      SZ_WORD: return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic legal_store(input logic [2:0] op, input logic [1:0] size);
    return (op == OP_ST) && (size != SZ_ILLEGAL);
  endfunction

endpackage

// File: rtl/d_store_split_align.sv
// Combinational store aligner: positions data and byte mask across a two-line
// window starting at the request's line, and reports the bank of the low line.
module d_store_align
  import d_store_split_pkg::*;
#(
  parameter int unsigned CL_SIZE = 128
) (
  input  logic [off_bits(CL_SIZE):0] addr,
  input  logic [31:0]                data,
  input  logic [1:0]                 size,
  output logic [CL_SIZE-1:0]         lo_data,
  output logic [CL_SIZE-1:0]         hi_data,
  output logic [CL_SIZE/8-1:0]       lo_mask,
  output logic [CL_SIZE/8-1:0]       hi_mask,
  output logic                       split,
  output logic                       lo_bank
);

  localparam int unsigned OFF_W = off_bits(CL_SIZE);
  localparam int unsigned MW    = CL_SIZE / 8;

  logic [OFF_W-1:0]     off;
  logic [2*CL_SIZE-1:0] full_data;
  logic [2*MW-1:0]      full_mask;

  always_comb begin
    off       = addr[OFF_W-1:0];
    full_data = {{(2*CL_SIZE-32){1'b0}}, data} << {off, 3'b000};
    full_mask = {{(2*MW-4){1'b0}}, size_mask(size)} << off;
    lo_data   = full_data[CL_SIZE-1:0];
    hi_data   = full_data[2*CL_SIZE-1:CL_SIZE];
    lo_mask   = full_mask[MW-1:0];
    hi_mask   = full_mask[2*MW-1:MW];
    split     = |full_mask[2*MW-1:MW];
    lo_bank   = addr[OFF_W];
  end

endmodule

// File: rtl/d_store_split.sv
// Store split path: aligns one ST into even/odd bank line writes, tracks
// per-bank handshake and ack, and reports a single completion.
module d_store_split
  import d_store_split_pkg::*;
#(
  parameter int unsigned CL_SIZE      = 128,
  parameter int unsigned OOO_TAG_SIZE = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [31:0]             req_addr,
  input  logic [31:0]             req_data,
  input  logic [1:0]              req_size,
  input  logic [2:0]              req_op,
  input  logic [OOO_TAG_SIZE-1:0] req_tag,
  output logic                    wr_valid_e,
  output logic                    wr_valid_o,
  input  logic                    wr_ready_e,
  input  logic                    wr_ready_o,
  output logic [31:0]             wr_addr_e,
  output logic [31:0]             wr_addr_o,
  output logic [CL_SIZE-1:0]      wr_data_e,
  output logic [CL_SIZE-1:0]      wr_data_o,
  output logic [CL_SIZE/8-1:0]    wr_mask_e,
  output logic [CL_SIZE/8-1:0]    wr_mask_o,
  output logic [OOO_TAG_SIZE-1:0] wr_tag_e,
  output logic [OOO_TAG_SIZE-1:0] wr_tag_o,
  input  logic                    ack_e,
  input  logic                    ack_o,
  output logic                    done_valid,
  output logic [OOO_TAG_SIZE-1:0] done_tag,
  output logic                    done_split,
  output logic                    done_err
);

  localparam int unsigned OFF_W = off_bits(CL_SIZE);
  localparam int unsigned MW    = CL_SIZE / 8;

  state_e                  state;
  logic                    need_e, need_o, acc_e, acc_o, ackd_e, ackd_o, split_q;
  logic [OOO_TAG_SIZE-1:0] tag_q;

  logic [CL_SIZE-1:0] lo_data, hi_data, e_data, o_data;
  logic [MW-1:0]      lo_mask, hi_mask, e_mask, o_mask;
  logic               split, lo_bank, need_e_in, need_o_in, legal;
  logic [31:0]        lo_addr, hi_addr, e_addr, o_addr;
  logic               hs_e, hs_o, acc_e_n, acc_o_n, ackd_e_n, ackd_o_n;
  logic               in_flight, all_acc, all_ack;

  d_store_align #(.CL_SIZE(CL_SIZE)) u_align (
    .addr    (req_addr[OFF_W:0]),
    .data    (req_data),
    .size    (req_size),
    .lo_data (lo_data),
    .hi_data (hi_data),
    .lo_mask (lo_mask),
    .hi_mask (hi_mask),
    .split   (split),
    .lo_bank (lo_bank)
  );

  // Low line lands in bank addr[OFF_W]; the spill line goes to the other bank.
  always_comb begin
    legal     = legal_store(req_op, req_size);
    lo_addr   = {req_addr[31:OFF_W], {OFF_W{1'b0}}};
    hi_addr   = lo_addr + 32'(MW);
    need_e_in = !lo_bank || split;
    need_o_in = lo_bank || split;
    e_addr    = need_e_in ? (lo_bank ? hi_addr : lo_addr) : '0;
    o_addr    = need_o_in ? (lo_bank ? lo_addr : hi_addr) : '0;
    e_data    = need_e_in ? (lo_bank ? hi_data : lo_data) : '0;
    o_data    = need_o_in ? (lo_bank ? lo_data : hi_data) : '0;
    e_mask    = need_e_in ? (lo_bank ? hi_mask : lo_mask) : '0;
    o_mask    = need_o_in ? (lo_bank ? lo_mask : hi_mask) : '0;
  end

  // Acks count only for needed banks already (or just now) accepted.
  always_comb begin
    in_flight = (state == S_ISSUE) || (state == S_WAIT);
    hs_e      = wr_valid_e && wr_ready_e;
    hs_o      = wr_valid_o && wr_ready_o;
    acc_e_n   = acc_e || hs_e;
    acc_o_n   = acc_o || hs_o;
    ackd_e_n  = ackd_e || (in_flight && need_e && acc_e_n && ack_e);
    ackd_o_n  = ackd_o || (in_flight && need_o && acc_o_n && ack_o);
    all_acc   = (acc_e_n || !need_e) && (acc_o_n || !need_o);
    all_ack   = (ackd_e_n || !need_e) && (ackd_o_n || !need_o);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      req_ready  <= 1'b0;
      need_e     <= 1'b0;
      need_o     <= 1'b0;
      acc_e      <= 1'b0;
      acc_o      <= 1'b0;
      ackd_e     <= 1'b0;
      ackd_o     <= 1'b0;
      split_q    <= 1'b0;
      tag_q      <= '0;
      wr_valid_e <= 1'b0;
      wr_valid_o <= 1'b0;
      wr_addr_e  <= '0;
      wr_addr_o  <= '0;
      wr_data_e  <= '0;
      wr_data_o  <= '0;
      wr_mask_e  <= '0;
      wr_mask_o  <= '0;
      wr_tag_e   <= '0;
      wr_tag_o   <= '0;
      done_valid <= 1'b0;
      done_tag   <= '0;
      done_split <= 1'b0;
      done_err   <= 1'b0;
    end else begin
      acc_e  <= acc_e_n;
      acc_o  <= acc_o_n;
      ackd_e <= ackd_e_n;
      ackd_o <= ackd_o_n;
      if (hs_e) wr_valid_e <= 1'b0;
      if (hs_o) wr_valid_o <= 1'b0;
      case (state)
        S_IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            tag_q     <= req_tag;
            acc_e     <= 1'b0;
            acc_o     <= 1'b0;
            ackd_e    <= 1'b0;
            ackd_o    <= 1'b0;
            if (!legal) begin
              state      <= S_DONE;
              need_e     <= 1'b0;
              need_o     <= 1'b0;
              split_q    <= 1'b0;
              done_valid <= 1'b1;
              done_tag   <= req_tag;
              done_split <= 1'b0;
              done_err   <= 1'b1;
            end else begin
              state      <= S_ISSUE;
              need_e     <= need_e_in;
              need_o     <= need_o_in;
              split_q    <= split;
              wr_valid_e <= need_e_in;
              wr_valid_o <= need_o_in;
              wr_addr_e  <= e_addr;
              wr_addr_o  <= o_addr;
              wr_data_e  <= e_data;
              wr_data_o  <= o_data;
              wr_mask_e  <= e_mask;
              wr_mask_o  <= o_mask;
              wr_tag_e   <= need_e_in ? req_tag : '0;
              wr_tag_o   <= need_o_in ? req_tag : '0;
            end
          end
        end
        S_ISSUE: begin
          if (all_acc) state <= S_WAIT;
        end
        S_WAIT: begin
          if (all_ack) begin
            state      <= S_DONE;
            done_valid <= 1'b1;
            done_tag   <= tag_q;
            done_split <= split_q;
            done_err   <= 1'b0;
          end
        end
        S_DONE: begin
          state      <= S_IDLE;
          req_ready  <= 1'b1;
          done_valid <= 1'b0;
          done_tag   <= '0;
          done_split <= 1'b0;
          done_err   <= 1'b0;
          wr_addr_e  <= '0;
          wr_addr_o  <= '0;
          wr_data_e  <= '0;
          wr_data_o  <= '0;
          wr_mask_e  <= '0;
          wr_mask_o  <= '0;
          wr_tag_e   <= '0;
          wr_tag_o   <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_d_store_split.sv
// Randomised bench for d_store_split with a byte-level reference model and
// reactive bank responders driven from the stimulus task.
module tb_d_store_split;

  localparam int TW = 10;

  logic           clk = 1'b0;
  logic           rst;
  logic           req_valid, req_ready;
  logic [31:0]    req_addr, req_data;
  logic [1:0]     req_size;
  logic [2:0]     req_op;
  logic [TW-1:0]  req_tag;
  logic           wr_valid_e, wr_valid_o, wr_ready_e, wr_ready_o;
  logic [31:0]    wr_addr_e, wr_addr_o;
  logic [127:0]   wr_data_e, wr_data_o;
  logic [15:0]    wr_mask_e, wr_mask_o;
  logic [TW-1:0]  wr_tag_e, wr_tag_o;
  logic           ack_e, ack_o;
  logic           done_valid, done_split, done_err;
  logic [TW-1:0]  done_tag;

  int checks   = 0;
  int failures = 0;

  logic [31:0]  m_addr[2];
  logic [127:0] m_data[2];
  logic [15:0]  m_mask[2];
  bit           m_need[2];
  bit           m_split;

  d_store_split #(.CL_SIZE(128), .OOO_TAG_SIZE(TW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_data(req_data), .req_size(req_size), .req_op(req_op), .req_tag(req_tag),
    .wr_valid_e(wr_valid_e), .wr_valid_o(wr_valid_o),
    .wr_ready_e(wr_ready_e), .wr_ready_o(wr_ready_o),
    .wr_addr_e(wr_addr_e), .wr_addr_o(wr_addr_o),
    .wr_data_e(wr_data_e), .wr_data_o(wr_data_o),
    .wr_mask_e(wr_mask_e), .wr_mask_o(wr_mask_o),
    .wr_tag_e(wr_tag_e), .wr_tag_o(wr_tag_o),
    .ack_e(ack_e), .ack_o(ack_o),
    .done_valid(done_valid), .done_tag(done_tag),
    .done_split(done_split), .done_err(done_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Byte-by-byte placement into the two-line window starting at the line of a.
  task automatic model(input logic [31:0] a, input logic [31:0] d, input int nb);
    logic [31:0] base;
    int off;
    base = {a[31:4], 4'h0};
    off  = int'(a[3:0]);
    for (int b = 0; b < 2; b++) begin
      m_need[b] = 0; m_addr[b] = '0; m_data[b] = '0; m_mask[b] = '0;
    end
    for (int i = 0; i < 4; i++) begin
      int pos, ln, bk;
      pos = off + i;
      if (pos < 32) begin
        ln = pos / 16;
        bk = int'(a[4]) ^ ln;
        m_data[bk][(pos % 16) * 8 +: 8] = d[i * 8 +: 8];
        m_addr[bk] = base + 32'(16 * ln);
        if (i < nb) begin
          m_need[bk] = 1;
          m_mask[bk][pos % 16] = 1'b1;
        end
      end
    end
    for (int b = 0; b < 2; b++)
      if (!m_need[b]) begin
        m_addr[b] = '0; m_data[b] = '0;
      end
    m_split = m_need[0] && m_need[1];
  endtask

  task automatic run_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                           input logic [2:0] op, input logic [TW-1:0] tag,
                           input int rdy_e, input int rdy_o, input int ackd_e, input int ackd_o,
                           input bit stray_e, input bit stray_o);
    int nb, w, done_n, done_c, exp_c;
    bit legal, reissue;
    int cnt[2], hs_c[2], dly[2], adly[2];
    bit accd[2], issued[2], rdy[2], ak[2], v[2];
    logic [31:0] ga[2];
    logic [127:0] gd[2];
    logic [15:0] gm[2];
    logic [TW-1:0] gt[2];

    nb    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd3) ? 4 : 0;
    legal = (op == 3'd2) && (sz != 2'd2);
    model(a, d, legal ? nb : 0);
    dly[0] = rdy_e; dly[1] = rdy_o; adly[0] = ackd_e; adly[1] = ackd_o;
    for (int b = 0; b < 2; b++) begin
      cnt[b] = 0; hs_c[b] = 0; accd[b] = 0; issued[b] = 0;
    end
    done_n = 0; done_c = -1; reissue = 0;

    w = 0;
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check_val("req_ready_idle", req_ready, 1'b1);
    req_addr = a; req_data = d; req_size = sz; req_op = op; req_tag = tag; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; req_data = $urandom; req_addr = $urandom; req_tag = TW'($urandom);

    for (int c = 1; c <= 60; c++) begin
      v[0] = wr_valid_e; ga[0] = wr_addr_e; gd[0] = wr_data_e; gm[0] = wr_mask_e; gt[0] = wr_tag_e;
      v[1] = wr_valid_o; ga[1] = wr_addr_o; gd[1] = wr_data_o; gm[1] = wr_mask_o; gt[1] = wr_tag_o;
      for (int b = 0; b < 2; b++) begin
        rdy[b] = 0;
        if (v[b]) begin
          if (accd[b]) reissue = 1;
          issued[b] = 1;
          check_val($sformatf("wr_addr%0d", b), ga[b], m_addr[b]);
          check_val($sformatf("wr_data%0d", b), gd[b], m_data[b]);
          check_val($sformatf("wr_mask%0d", b), gm[b], m_mask[b]);
          check_val($sformatf("wr_tag%0d", b), gt[b], tag);
          if (!accd[b] && cnt[b] >= dly[b]) begin
            rdy[b] = 1; accd[b] = 1; hs_c[b] = c;
          end
          cnt[b]++;
        end else if (c == 1 && !m_need[b]) begin
          check_val($sformatf("unused_addr%0d", b), ga[b], 32'h0);
          check_val($sformatf("unused_data%0d", b), {gd[b][111:0], gm[b]}, 128'h0);
        end
        ak[b] = accd[b] && (c == hs_c[b] + adly[b]);
      end
      if (stray_e && !m_need[0] && c == 2) ak[0] = 1;
      if (stray_o && !m_need[1] && c == 2) ak[1] = 1;
      if (done_valid) begin
        done_n++;
        if (done_n == 1) begin
          done_c = c;
          check_val("done_tag", done_tag, tag);
          check_val("done_split", done_split, m_split);
          check_val("done_err", done_err, !legal);
        end
      end
      wr_ready_e = rdy[0]; wr_ready_o = rdy[1]; ack_e = ak[0]; ack_o = ak[1];
      @(negedge clk);
      if (done_c > 0 && c >= done_c + 2) break;
    end
    wr_ready_e = 0; wr_ready_o = 0; ack_e = 0; ack_o = 0;

    check_val("done_count", done_n, 1);
    check_val("no_reissue", reissue, 1'b0);
    check_val("issued_e", issued[0], m_need[0]);
    check_val("issued_o", issued[1], m_need[1]);
    if (legal) begin
      exp_c = 0;
      for (int b = 0; b < 2; b++)
        if (m_need[b]) begin
          if (hs_c[b] + adly[b] + 1 > exp_c) exp_c = hs_c[b] + adly[b] + 1;
          if (hs_c[b] + 2 > exp_c) exp_c = hs_c[b] + 2;
        end
      check_val("done_cycle", 128'(done_c), 128'(exp_c));
    end else begin
      check_val("err_latency", (done_c >= 1 && done_c <= 2), 1'b1);
    end
  endtask

  initial begin
    rst = 1'b0; req_valid = 0; req_addr = '0; req_data = '0; req_size = '0; req_op = '0;
    req_tag = '0; wr_ready_e = 0; wr_ready_o = 0; ack_e = 0; ack_o = 0;
    #1;
    check_val("rst_req_ready", req_ready, 1'b0);
    check_val("rst_outs", {wr_valid_e, wr_valid_o, done_valid, done_split, done_err, done_tag,
                           wr_addr_e, wr_addr_o}, '0);
    check_val("rst_data", wr_data_e | wr_data_o, '0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_val("post_rst_req_ready", req_ready, 1'b1);

    // Directed cases
    run_store(32'h1004, 32'hDEADBEEF, 2'd3, 3'd2, 10'h011, 0, 0, 0, 0, 0, 0);
    run_store(32'h101F, 32'h0000A1B2, 2'd1, 3'd2, 10'h022, 0, 0, 0, 0, 0, 0);
    run_store(32'h301E, 32'h12345678, 2'd3, 3'd2, 10'h033, 0, 5, 0, 1, 0, 0);
    run_store(32'h4000, 32'h55AA55AA, 2'd2, 3'd2, 10'h044, 0, 0, 0, 0, 0, 0);
    run_store(32'h4000, 32'h55AA55AA, 2'd3, 3'd1, 10'h055, 0, 0, 0, 0, 0, 0);
    run_store(32'h5008, 32'h000000C3, 2'd0, 3'd2, 10'h066, 0, 0, 4, 0, 0, 1);
    run_store(32'hFFFF_FFFE, 32'hCAFEF00D, 2'd3, 3'd2, 10'h077, 1, 2, 2, 0, 0, 0);

    // Reset while waiting for an ack
    wait_ready_and_issue();

    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      logic [1:0]  sz;
      logic [2:0]  op;
      a = $urandom;
      if (i % 8 == 0) a = {28'hFFFFFFF, 4'($urandom_range(0, 15))};
      case ($urandom_range(0, 9))
        0:       sz = 2'd2;
        1, 2, 3: sz = 2'd0;
        4, 5, 6: sz = 2'd1;
        default: sz = 2'd3;
      endcase
      op = ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'd2;
      run_store(a, $urandom, sz, op, TW'($urandom),
                $urandom_range(0, 4), $urandom_range(0, 4),
                $urandom_range(0, 4), $urandom_range(0, 4),
                1'($urandom), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  task automatic wait_ready_and_issue();
    int w;
    bit saw_done;
    w = 0;
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    req_addr = 32'h2004; req_data = 32'h0BADF00D; req_size = 2'd3; req_op = 3'd2;
    req_tag = 10'h3A5; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    check_val("rst_case_issue", wr_valid_e, 1'b1);
    wr_ready_e = 1'b1;
    @(negedge clk);
    wr_ready_e = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check_val("async_rst_valid", {wr_valid_e, wr_valid_o, done_valid, req_ready}, 4'h0);
    check_val("async_rst_addr", {wr_addr_e, wr_tag_e, wr_mask_e}, '0);
    check_val("async_rst_data", wr_data_e, '0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    saw_done = 0;
    repeat (6) begin
      @(negedge clk);
      if (done_valid) saw_done = 1;
    end
    check_val("rst_no_done", saw_done, 1'b0);
    run_store(32'h2004, 32'h0BADF00D, 2'd3, 3'd2, 10'h3A6, 0, 0, 1, 0, 0, 0);
  endtask

endmodule
